// File: rtl/n_register_chain_pkg.sv
// Shared constants for the matrix-multiply operand skew lines.
// Defaults for the word width and the skew depth live here.
package n_register_chain_pkg;

    localparam int DATA_W     = 16;
    localparam int SKEW_DEPTH = 4;

endpackage : n_register_chain_pkg

// File: rtl/n_register_chain_register_stage.sv
// One W-bit delay-line stage: a plain D flop with a synchronous clear.
module register_stage #(
    parameter int W = 16
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    // Reset takes priority over the incoming word on the same edge.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_q <= '0;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule : register_stage

// File: rtl/n_register_chain.sv
// Parameterised delay line: a word on 'in' appears on 'out' N rising edges later.
// Used to skew and align operand streams between matrix-multiply processing elements.
module n_register_chain
    import n_register_chain_pkg::*;
#(
    parameter int N = SKEW_DEPTH,
    parameter int W = DATA_W
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic [W-1:0] in,
    output logic [W-1:0] out
);

    generate
        if (N < 0 || W < 1) begin : g_illegal
            $error("n_register_chain: N must be >= 0 and W must be >= 1");
            assign out = '0;
        end else if (N == 0) begin : g_passthrough
            // Zero depth degenerates to a wire; clock and reset have no effect.
            logic w_unused;
            assign w_unused = Clock ^ Reset;
            assign out      = in;
        end else begin : g_chain
            logic [N-1:0][W-1:0] w_stage;

            for (genvar k = 0; k < N; k++) begin : g_stage
                logic [W-1:0] w_stageIn;

                if (k == 0) begin : g_head
                    assign w_stageIn = in;
                end else begin : g_link
                    assign w_stageIn = w_stage[k-1];
                end

                register_stage #(
                    .W(W)
                ) u_stage (
                    .Clock (Clock),
                    .Reset (Reset),
                    .i_d   (w_stageIn),
                    .o_q   (w_stage[k])
                );
            end

            assign out = w_stage[N-1];
        end
    endgenerate

endmodule : n_register_chain

// File: tb/tb_n_register_chain.sv
// Self-checking bench for n_register_chain at depths 4, 1 and 0, driven with
// directed sequences followed by randomized data and resets.
module tb_n_register_chain;

   localparam int W            = 16;
   localparam int CLOCK_PERIOD = 10;
   localparam int MAX_EDGES    = 1024;

   logic          clock;
   logic          reset;
   logic [W-1:0]  dataIn;
   logic [W-1:0]  out4;
   logic [W-1:0]  out1;
   logic [W-1:0]  out0;

   int            compareCount;
   int            mismatchCount;
   int            edgeIdx;

   logic [W-1:0]  inHist  [MAX_EDGES];
   bit            rstHist [MAX_EDGES];

   n_register_chain #(4, W) dut4 (
      .Clock (clock),
      .Reset (reset),
      .in    (dataIn),
      .out   (out4)
   );

   n_register_chain #(1, W) dut1 (
      .Clock (clock),
      .Reset (reset),
      .in    (dataIn),
      .out   (out1)
   );

   n_register_chain #(0, W) dut0 (
      .Clock (clock),
      .Reset (reset),
      .in    (dataIn),
      .out   (out0)
   );

   // Free-running clock shared by every instance.
   initial begin
      clock = 1'b0;
      forever #(CLOCK_PERIOD / 2) clock = ~clock;
   end

   // A delay line of the given depth shows, after edge k, the word captured
   // depth-1 edges earlier, unless any reset happened in that window.
   function automatic logic [W-1:0] expectedOut(input int depth, input int k);
      int start;
      start = k - depth + 1;
      if (start < 0) return '0;
      for (int j = start; j <= k; j++) begin
         if (rstHist[j]) return '0;
      end
      return inHist[start];
   endfunction

   task automatic checkOutput(input string tag, input logic [W-1:0] got,
                              input logic [W-1:0] exp);
      compareCount++;
      if (got !== exp) begin
         mismatchCount++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Drive one cycle of inputs, check the combinational path, then advance
   // one edge and check both registered chains against the model.
   task automatic applyStimulus(input logic rst, input logic [W-1:0] data);
      reset  = rst;
      dataIn = data;
      #1;
      checkOutput($sformatf("n0 pass e%0d", edgeIdx), out0, data);
      @(posedge clock);
      inHist[edgeIdx]  = data;
      rstHist[edgeIdx] = rst;
      #1;
      checkOutput($sformatf("n4 e%0d", edgeIdx), out4, expectedOut(4, edgeIdx));
      checkOutput($sformatf("n1 e%0d", edgeIdx), out1, expectedOut(1, edgeIdx));
      edgeIdx++;
   endtask

   initial begin
      logic [W-1:0] seqWords [4];
      compareCount  = 0;
      mismatchCount = 0;
      edgeIdx       = 0;
      reset         = 1'b1;
      dataIn        = 16'hFFFF;

      // Reset held for two edges while the input is all ones.
      applyStimulus(1'b1, 16'hFFFF);
      checkOutput("reset out4", out4, 16'h0000);
      checkOutput("reset out1", out1, 16'h0000);
      applyStimulus(1'b1, 16'hFFFF);

      // Four distinct words back to back, then flush with zeros.
      seqWords[0] = 16'h4A55;
      seqWords[1] = 16'h515F;
      seqWords[2] = 16'hA5A5;
      seqWords[3] = 16'h0001;
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, seqWords[i]);
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 16'h0000);

      // Single-cycle pulse must appear for exactly one cycle.
      applyStimulus(1'b0, 16'hCCCC);
      for (int i = 0; i < 6; i++) applyStimulus(1'b0, 16'h0000);

      // Stream interrupted by a reset after the fifth word.
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, W'(16'h1100 + i));
      applyStimulus(1'b1, 16'hBEEF);
      checkOutput("midreset out4", out4, 16'h0000);
      for (int i = 5; i < 8; i++) applyStimulus(1'b0, W'(16'h1100 + i));
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 16'h0000);

      // Constant input settles and holds.
      for (int i = 0; i < 6; i++) applyStimulus(1'b0, 16'h1234);
      checkOutput("hold out4", out4, 16'h1234);

      // Randomized data with occasional resets.
      for (int i = 0; i < 300; i++) begin
         applyStimulus(($urandom_range(0, 19) == 0), W'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule : tb_n_register_chain
